// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the five-stage pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    LU_STALL = 2'd3
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  localparam int PC_W_DEF  = 4;
  localparam int REG_W_DEF = 5;
  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a load in EX is about to write.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             suppress,
  output logic             lu
);

  logic [REG_W-1:0] rs_diff;
  logic [REG_W-1:0] rt_diff;

  generate
    for (genvar gi = 0; gi < REG_W; gi++) begin : g_cmp
      assign rs_diff[gi] = ex_rt[gi] ^ id_rs[gi];
      assign rt_diff[gi] = ex_rt[gi] ^ id_rt[gi];
    end
  endgenerate

  // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign lu = ex_memread && (|ex_rt) && !suppress &&
              (!(|rs_diff) || (id_uses_rt && !(|rt_diff)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: freeze / branch flush / load-use stall with performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic [PC_W-1:0]  ex_branch_target,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [PC_W-1:0]  pc_target,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t           state_reg;
  state_t           state_next;
  logic             lu;
  logic             lu_suppress;
  logic             flush_inc;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  assign lu_suppress = (state_reg == FLUSH) || (state_reg == LU_STALL);

  hazard_detect #(
    .REG_W(REG_W)
  ) u_hazard_detect (
    .ex_memread(ex_memread),
    .ex_rt     (ex_rt),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_uses_rt(id_uses_rt),
    .suppress  (lu_suppress),
    .lu        (lu)
  );

  // MEM_WAIT needs no dedicated branch: once mem_busy drops it decodes like RUN.
  always_comb begin
    pc_we       = 1'b0;
    pc_sel      = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_bubble = 1'b0;
    exmem_en    = 1'b0;
    flush_inc   = 1'b0;
    state_next  = RUN;
    if (!rst_n) begin
      state_next = RUN;
    end else if (mem_busy) begin
      state_next = MEM_WAIT;
    end else if (ex_branch_taken) begin
      pc_we       = 1'b1;
      pc_sel      = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b1;
      idex_en     = 1'b1;
      idex_bubble = 1'b1;
      exmem_en    = 1'b1;
      flush_inc   = 1'b1;
      state_next  = FLUSH;
    end else if (lu) begin
      idex_en     = 1'b1;
      idex_bubble = 1'b1;
      exmem_en    = 1'b1;
      state_next  = LU_STALL;
    end else begin
      pc_we    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RUN;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (!pc_we && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (flush_inc && (flush_cnt_reg != {CNT_W{1'b1}}))
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

  assign pc_target = ex_branch_target;
  assign state     = state_reg;
  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; control outputs packed as {pc_we,pc_sel,ifid_en,ifid_flush,idex_en,idex_bubble,exmem_en}.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic [3:0]  ex_branch_target;
  logic        mem_busy;
  logic        pc_we;
  logic        pc_sel;
  logic [3:0]  pc_target;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_en;
  logic        idex_bubble;
  logic        exmem_en;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [6:0]  ctl;

  int checks;
  int errors;
  int exp_stall;
  int exp_flush;

  localparam logic [6:0] CTL_RUN    = 7'b1010101;
  localparam logic [6:0] CTL_BRANCH = 7'b1111111;
  localparam logic [6:0] CTL_LU     = 7'b0000111;
  localparam logic [6:0] CTL_FREEZE = 7'b0000000;

  assign ctl = {pc_we, pc_sel, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en};

  pipe_hazard_ctrl #(.PC_W(4), .REG_W(5), .CNT_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_memread      (ex_memread),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .ex_branch_target(ex_branch_target),
    .mem_busy        (mem_busy),
    .pc_we           (pc_we),
    .pc_sel          (pc_sel),
    .pc_target       (pc_target),
    .ifid_en         (ifid_en),
    .ifid_flush      (ifid_flush),
    .idex_en         (idex_en),
    .idex_bubble     (idex_bubble),
    .exmem_en        (exmem_en),
    .state           (state),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_memread = 0; ex_rt = 0;
    ex_branch_taken = 0; ex_branch_target = 0; mem_busy = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    #1;
    checks++;
    if (ctl !== CTL_FREEZE) begin errors++; $display("FAIL reset_ctl got %b want %b", ctl, CTL_FREEZE); end
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_stall = 0;
    exp_flush = 0;
  endtask

  task automatic test_run();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (ctl !== CTL_RUN || state !== 2'd0) begin
        errors++; $display("FAIL run_cycle%0d got ctl=%b state=%0d want ctl=%b state=0", i, ctl, state, CTL_RUN);
      end
    end
    tick();
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++; $display("FAIL run_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    ex_memread = 1; ex_rt = 5; id_rs = 5;
    #1;
    checks++;
    if (ctl !== CTL_LU) begin errors++; $display("FAIL lu_ctl got %b want %b", ctl, CTL_LU); end
    tick();
    exp_stall++;
    checks++;
    if (state !== 2'd3) begin errors++; $display("FAIL lu_state got %0d want 3", state); end
    @(negedge clk);
    #1;
    checks++;
    if (ctl !== CTL_RUN) begin errors++; $display("FAIL lu_suppressed got %b want %b", ctl, CTL_RUN); end
    tick();
    checks++;
    if (state !== 2'd0 || stall_cnt !== 16'(exp_stall)) begin
      errors++; $display("FAIL lu_done got state=%0d stall=%0d want state=0 stall=%0d", state, stall_cnt, exp_stall);
    end
    // load to r0 never stalls
    @(negedge clk);
    ex_rt = 0; id_rs = 0;
    #1;
    checks++;
    if (ctl !== CTL_RUN) begin errors++; $display("FAIL lu_r0 got %b want %b", ctl, CTL_RUN); end
    // rt match only counts when the instruction reads rt
    @(negedge clk);
    ex_rt = 7; id_rs = 3; id_rt = 7; id_uses_rt = 0;
    #1;
    checks++;
    if (ctl !== CTL_RUN) begin errors++; $display("FAIL lu_rt_unused got %b want %b", ctl, CTL_RUN); end
    id_uses_rt = 1;
    #1;
    checks++;
    if (ctl !== CTL_LU) begin errors++; $display("FAIL lu_rt_used got %b want %b", ctl, CTL_LU); end
    tick();
    exp_stall++;
    @(negedge clk);
    clear_inputs();
    tick();
    checks++;
    if (state !== 2'd0 || stall_cnt !== 16'(exp_stall)) begin
      errors++; $display("FAIL lu_rt_done got state=%0d stall=%0d want state=0 stall=%0d", state, stall_cnt, exp_stall);
    end
  endtask

  task automatic test_branch();
    @(negedge clk);
    ex_branch_taken = 1; ex_branch_target = 4'hA;
    #1;
    checks++;
    if (ctl !== CTL_BRANCH || pc_target !== 4'hA) begin
      errors++; $display("FAIL br_ctl got ctl=%b tgt=%h want ctl=%b tgt=a", ctl, pc_target, CTL_BRANCH);
    end
    tick();
    exp_flush++;
    checks++;
    if (state !== 2'd2 || flush_cnt !== 16'(exp_flush)) begin
      errors++; $display("FAIL br_state got state=%0d flush=%0d want state=2 flush=%0d", state, flush_cnt, exp_flush);
    end
    @(negedge clk);
    ex_branch_taken = 0; ex_memread = 1; ex_rt = 5; id_rs = 5;
    #1;
    checks++;
    if (ctl !== CTL_RUN) begin errors++; $display("FAIL br_lu_suppressed got %b want %b", ctl, CTL_RUN); end
    tick();
    checks++;
    if (state !== 2'd0 || stall_cnt !== 16'(exp_stall)) begin
      errors++; $display("FAIL br_after got state=%0d stall=%0d want state=0 stall=%0d", state, stall_cnt, exp_stall);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_mem_busy();
    @(negedge clk);
    ex_memread = 1; ex_rt = 9; id_rs = 9; mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== CTL_FREEZE) begin errors++; $display("FAIL mb_freeze%0d got %b want %b", i, ctl, CTL_FREEZE); end
      tick();
      exp_stall++;
      checks++;
      if (state !== 2'd1) begin errors++; $display("FAIL mb_state%0d got %0d want 1", i, state); end
      @(negedge clk);
    end
    mem_busy = 0;
    #1;
    checks++;
    if (ctl !== CTL_LU) begin errors++; $display("FAIL mb_then_lu got %b want %b", ctl, CTL_LU); end
    tick();
    exp_stall++;
    checks++;
    if (state !== 2'd3 || stall_cnt !== 16'(exp_stall)) begin
      errors++; $display("FAIL mb_lu_state got state=%0d stall=%0d want state=3 stall=%0d", state, stall_cnt, exp_stall);
    end
    @(negedge clk);
    clear_inputs();
    tick();
  endtask

  task automatic test_branch_and_lu();
    @(negedge clk);
    ex_branch_taken = 1; ex_branch_target = 4'h3; ex_memread = 1; ex_rt = 4; id_rs = 4;
    #1;
    checks++;
    if (ctl !== CTL_BRANCH || pc_target !== 4'h3) begin
      errors++; $display("FAIL brlu_ctl got ctl=%b tgt=%h want ctl=%b tgt=3", ctl, pc_target, CTL_BRANCH);
    end
    tick();
    exp_flush++;
    checks++;
    if (state !== 2'd2 || flush_cnt !== 16'(exp_flush) || stall_cnt !== 16'(exp_stall)) begin
      errors++; $display("FAIL brlu_state got state=%0d flush=%0d stall=%0d want 2/%0d/%0d",
                         state, flush_cnt, stall_cnt, exp_flush, exp_stall);
    end
    @(negedge clk);
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_freeze();
    @(negedge clk);
    mem_busy = 1;
    tick();
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL rmid_pre got %0d want 1", state); end
    @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if (state !== 2'd0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || ctl !== CTL_FREEZE) begin
      errors++; $display("FAIL rmid_reset got state=%0d stall=%0d flush=%0d ctl=%b want 0/0/0/%b",
                         state, stall_cnt, flush_cnt, ctl, CTL_FREEZE);
    end
    @(negedge clk);
    rst_n = 1;
    mem_busy = 0;
    exp_stall = 0;
    exp_flush = 0;
    #1;
    checks++;
    if (ctl !== CTL_RUN) begin errors++; $display("FAIL rmid_run got %b want %b", ctl, CTL_RUN); end
    tick();
    checks++;
    if (state !== 2'd0 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL rmid_after got state=%0d stall=%0d want 0/0", state, stall_cnt);
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    force dut.stall_cnt_reg = 16'hFFFE;
    #1;
    release dut.stall_cnt_reg;
    mem_busy = 1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_stall got %h want ffff", stall_cnt); end
    @(negedge clk);
    mem_busy = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_run();
    test_load_use();
    test_branch();
    test_mem_busy();
    test_branch_and_lu();
    test_reset_mid_freeze();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the five-stage processor. Each cycle it generates the write-enable, flush and bubble controls for the PC, the IF/ID register (`enable` input) and the ID/EX and EX/MEM registers. It resolves three hazard classes with fixed priority: data-memory busy (global freeze), taken branch resolved in EX (flush), and load-use (one-cycle stall). It also keeps saturating stall and flush counters for performance observation.

## Interface
- `PC_W`, 4, width of PC and branch target
- `REG_W`, 5, register-specifier width
- `CNT_W`, 16, width of performance counters

Ports:
- `clk` in 1 rising-edge clock
- `rst_n` in 1 asynchronous active-low reset
- `id_rs` in REG_W source register of instruction in ID
- `id_rt` in REG_W second source of instruction in ID
- `id_uses_rt` in 1 ID instruction reads `id_rt`
- `ex_memread` in 1 instruction in EX is a load
- `ex_rt` in REG_W destination of load in EX
- `ex_branch_taken` in 1 branch in EX resolved taken
- `ex_branch_target` in PC_W branch target from EX
- `mem_busy` in 1 data memory not ready, MEM stage must hold
- `pc_we` out 1 PC register write enable
- `pc_sel` out 1 0 = sequential PC, 1 = `pc_target`
- `pc_target` out PC_W redirect address (passthrough of `ex_branch_target`)
- `ifid_en` out 1 drives IF/ID `enable`
- `ifid_flush` out 1 IF/ID loads NOP (32'h0) instead of fetched instruction
- `idex_en` out 1 ID/EX write enable
- `idex_bubble` out 1 ID/EX loads all-zero control (bubble)
- `exmem_en` out 1 EX/MEM write enable
- `state` out 2 current FSM state
- `stall_cnt` out CNT_W cycles with `pc_we`=0 outside reset
- `flush_cnt` out CNT_W taken-branch flushes

## Operation
- States: RUN=0, MEM_WAIT=1, FLUSH=2, LU_STALL=3. Outputs are Mealy (current state plus current inputs).
- Load-use hazard `lu` = `ex_memread` && `ex_rt`!=0 && (`ex_rt`==`id_rs` || (`id_uses_rt` && `ex_rt`==`id_rt`)). `lu` is suppressed (forced 0) in FLUSH and LU_STALL.
- Priority 1, `mem_busy`=1 (any state): freeze. `pc_we`=`ifid_en`=`idex_en`=`exmem_en`=0, flush/bubble=0. Next state MEM_WAIT. Branch and `lu` are ignored; EX is frozen, so they re-present when the freeze ends.
- Priority 2, `ex_branch_taken`=1: `pc_we`=1, `pc_sel`=1, `ifid_en`=1, `ifid_flush`=1, `idex_en`=1, `idex_bubble`=1, `exmem_en`=1. Next state FLUSH. `flush_cnt`+1.
- Priority 3, `lu`=1: `pc_we`=0, `ifid_en`=0, `idex_en`=1, `idex_bubble`=1, `exmem_en`=1. Next state LU_STALL.
- Otherwise: all enables 1, `pc_sel`=0, flush/bubble 0. Next state RUN.
- MEM_WAIT with `mem_busy`=0 is evaluated exactly as RUN in the same cycle (no dead cycle).
- `stall_cnt` increments on every clocked cycle with `pc_we`=0. Both counters saturate at all-ones.
- Simultaneous branch and `lu`: branch wins. The stalled instruction is a wrong-path instruction and is flushed.

## Timing
- Reset (`rst_n`=0, async): state=RUN, counters=0. All enables, `pc_sel`, flush and bubble are forced 0 combinationally while reset is asserted.
- First edge after deassertion: normal RUN behaviour.
- Reset mid-freeze or mid-flush: abandons the sequence; no pending action survives.
- Branch penalty is 2 cycles (IF and ID killed at the same edge). Load-use penalty is 1 cycle.
- Control outputs are combinational from inputs (zero latency). State and counters update on `posedge clk`.

## Structure
- Package `pipe_ctrl_pkg`: state enum (RUN/MEM_WAIT/FLUSH/LU_STALL), `NOP_INSTR`=32'h0, default widths.
- Sub-module `hazard_detect`: combinational load-use comparator producing `lu`. The FSM, output decode and counters live in the top.

## Test plan
- Reset released, no hazards: all enables 1, `state`=0, counters stay 0 over 10 cycles.
- `ex_memread`=1, `ex_rt`=5, `id_rs`=5: one cycle with `pc_we`=0, `ifid_en`=0, `idex_bubble`=1, then `state`=3, then RUN; `stall_cnt`=1. Repeat with `ex_rt`=0: no stall.
- `ex_branch_taken`=1, target=4'hA: `pc_sel`=1, `pc_target`=4'hA, `ifid_flush`=`idex_bubble`=1, next `state`=2, `flush_cnt`=1. In FLUSH, a matching `lu` pattern produces no stall.
- `mem_busy` high 3 cycles during a load-use pattern: 3 frozen cycles (all enables 0, `state`=1), then the load-use stall; `stall_cnt`=4.
- Branch and `lu` together: flush only, no stall. Reset asserted in MEM_WAIT: `state`=0 and counters=0 immediately.
- Preload counters near saturation (force 16'hFFFE): after 3 stall cycles, `stall_cnt`=16'hFFFF.
